// File: rtl/conv2_window_feeder.sv
// Streaming 3x3x3 window generator for the conv2 filter stage: two line
// buffers per channel feed a shifting window, emitted with a valid/ready handshake.
module conv2_window_feeder #(
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int CW    = 4,
  parameter int RW    = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_pix,
  output logic [53:0] A1,
  output logic [53:0] A2,
  output logic [53:0] A3,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        frame_done
);

  // All three channels travel together as one 18-bit pixel word.
  logic [17:0] lb0 [IMG_W];
  logic [17:0] lb1 [IMG_W];
  logic [17:0] win [3][3];

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept;
  logic emit;
  logic last_pix;
  logic col_last;
  logic row_last;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign last_pix = accept && row_last && col_last;

  // NOTE: line buffers are plain storage with no reset; rows 0-1 of every
  // frame rewrite them before they can reach an emitted window.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_pix;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which the left shift below depends on.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= in_pix;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A held window stays valid until consumed; a new one always wins.
      if (emit)
        win_valid <= 1'b1;
      else if (win_ready)
        win_valid <= 1'b0;
      frame_done <= last_pix;
    end
  end

  // NOTE: outputs get a full default before the loop so no latch is inferred.
  always_comb begin
    A1 = '0;
    A2 = '0;
    A3 = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        A1[6*(3*i+j) +: 6] = win[i][j][5:0];
        A2[6*(3*i+j) +: 6] = win[i][j][11:6];
        A3[6*(3*i+j) +: 6] = win[i][j][17:12];
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_feeder.sv
// Directed bench for conv2_window_feeder: 4x4 frame scenarios on one instance,
// 3x3 all-ones boundary on a second instance.
module tb_conv2_window_feeder;

  logic        CLK;
  logic        CLR;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_pix;
  logic [53:0] A1, A2, A3;
  logic        win_valid;
  logic        win_ready;
  logic        frame_done;

  logic        in_valid3;
  logic        in_ready3;
  logic [17:0] in_pix3;
  logic [53:0] B1, B2, B3;
  logic        win_valid3;
  logic        win_ready3;
  logic        frame_done3;

  int total;
  int bad;

  conv2_window_feeder #(.IMG_W(4), .IMG_H(4), .CW(2), .RW(2)) dut (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .A1(A1), .A2(A2), .A3(A3), .win_valid(win_valid),
    .win_ready(win_ready), .frame_done(frame_done)
  );

  conv2_window_feeder #(.IMG_W(3), .IMG_H(3), .CW(2), .RW(2)) dut3 (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_pix(in_pix3), .A1(B1), .A2(B2), .A3(B3), .win_valid(win_valid3),
    .win_ready(win_ready3), .frame_done(frame_done3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pixel p of a 4x4 frame: ch1 = p, ch2 = p+16, ch3 = p+32.
  function automatic logic [17:0] pix_of(int p);
    return {6'(p + 32), 6'(p + 16), 6'(p)};
  endfunction

  // Window ending at pixel (r,c) of the 4x4 pattern, one channel offset.
  function automatic logic [53:0] exp_win(int r, int c, int off);
    logic [53:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[6*(3*i+j) +: 6] = 6'(4 * (r - 2 + i) + (c - 2 + j) + off);
    return w;
  endfunction

  function automatic logic [161:0] exp_all(int r, int c);
    return {exp_win(r, c, 32), exp_win(r, c, 16), exp_win(r, c, 0)};
  endfunction

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic drive(input logic v, input logic [17:0] pix, input logic wr,
                       output logic acc);
    in_valid  = v;
    in_pix    = pix;
    win_ready = wr;
    #2;
    acc = v && in_ready;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    in_pix     = '0;
    win_ready  = 1'b1;
    in_valid3  = 1'b0;
    in_pix3    = '0;
    win_ready3 = 1'b1;
    #1 CLR = 1'b1;
    #2 CLR = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    in_valid   = 1'b0;
    in_pix     = '0;
    win_ready  = 1'b0;
    in_valid3  = 1'b0;
    in_pix3    = '0;
    win_ready3 = 1'b0;
    CLR = 1'b1;
    #1;
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid got=%b want=0", win_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if ({A3, A2, A1} !== 162'd0) begin bad++; $display("FAIL reset_window got=%h want=0", {A3, A2, A1}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge CLK);
    #2 CLR = 1'b0;
    @(posedge CLK);
    #1;
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_win_valid got=%b want=0", win_valid); end
  endtask

  task automatic test_basic();
    logic acc;
    int   nwin;
    int   r, c;
    logic em;
    do_reset();
    nwin = 0;
    for (int idx = 0; idx < 16; idx++) begin
      r = idx / 4; c = idx % 4;
      em = (r >= 2) && (c >= 2);
      drive(1'b1, pix_of(idx), 1'b1, acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL basic_accept idx=%0d got=%b want=1", idx, acc); end
      total++; if (win_valid !== em) begin bad++; $display("FAIL basic_win_valid idx=%0d got=%b want=%b", idx, win_valid, em); end
      total++; if (frame_done !== (idx == 15)) begin bad++; $display("FAIL basic_frame_done idx=%0d got=%b want=%b", idx, frame_done, idx == 15); end
      if (win_valid) nwin++;
      if (em) begin
        total++; if ({A3, A2, A1} !== exp_all(r, c)) begin bad++; $display("FAIL basic_window idx=%0d got=%h want=%h", idx, {A3, A2, A1}, exp_all(r, c)); end
      end
      if (idx == 10) begin
        total++;
        if (A1 !== {6'd10, 6'd9, 6'd8, 6'd6, 6'd5, 6'd4, 6'd2, 6'd1, 6'd0}) begin
          bad++; $display("FAIL basic_first_ch1 got=%h want=%h", A1, {6'd10, 6'd9, 6'd8, 6'd6, 6'd5, 6'd4, 6'd2, 6'd1, 6'd0});
        end
        total++;
        if (A3 !== {6'd42, 6'd41, 6'd40, 6'd38, 6'd37, 6'd36, 6'd34, 6'd33, 6'd32}) begin
          bad++; $display("FAIL basic_first_ch3 got=%h want=%h", A3, {6'd42, 6'd41, 6'd40, 6'd38, 6'd37, 6'd36, 6'd34, 6'd33, 6'd32});
        end
      end
      if (idx == 15) begin
        total++;
        if (A1 !== {6'd15, 6'd14, 6'd13, 6'd11, 6'd10, 6'd9, 6'd7, 6'd6, 6'd5}) begin
          bad++; $display("FAIL basic_last_ch1 got=%h want=%h", A1, {6'd15, 6'd14, 6'd13, 6'd11, 6'd10, 6'd9, 6'd7, 6'd6, 6'd5});
        end
      end
    end
    total++; if (nwin !== 4) begin bad++; $display("FAIL basic_window_count got=%0d want=4", nwin); end
  endtask

  task automatic test_backpressure();
    logic acc;
    int   nwin;
    int   r, c;
    logic em;
    do_reset();
    for (int idx = 0; idx < 11; idx++) drive(1'b1, pix_of(idx), 1'b1, acc);
    total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b want=1", win_valid); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, pix_of(11), 1'b0, acc);
      total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", k, acc); end
      total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cycle=%0d got=%b want=1", k, win_valid); end
      total++; if ({A3, A2, A1} !== exp_all(2, 2)) begin bad++; $display("FAIL bp_hold_window cycle=%0d got=%h want=%h", k, {A3, A2, A1}, exp_all(2, 2)); end
    end
    nwin = 0;
    for (int idx = 11; idx < 16; idx++) begin
      r = idx / 4; c = idx % 4;
      em = (r >= 2) && (c >= 2);
      drive(1'b1, pix_of(idx), 1'b1, acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_release_accept idx=%0d got=%b want=1", idx, acc); end
      total++; if (win_valid !== em) begin bad++; $display("FAIL bp_release_valid idx=%0d got=%b want=%b", idx, win_valid, em); end
      if (em) begin
        nwin++;
        total++; if ({A3, A2, A1} !== exp_all(r, c)) begin bad++; $display("FAIL bp_release_window idx=%0d got=%h want=%h", idx, {A3, A2, A1}, exp_all(r, c)); end
      end
    end
    total++; if (nwin !== 3) begin bad++; $display("FAIL bp_window_count got=%0d want=3", nwin); end
    drive(1'b0, '0, 1'b0, acc);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL bp_frame_done_pulse got=%b want=0", frame_done); end
    total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL bp_last_hold got=%b want=1", win_valid); end
  endtask

  task automatic test_bubbles();
    logic           acc, v, wr, exp_wv, exp_acc, em;
    logic [161:0]   held;
    int             idx, cyc, nwin, r, c;
    do_reset();
    idx = 0; cyc = 0; nwin = 0;
    exp_wv = 1'b0;
    held = '0;
    while (idx < 16 && cyc < 400) begin
      v  = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 3) != 0);
      exp_acc = v && (!exp_wv || wr);
      r = idx / 4; c = idx % 4;
      em = exp_acc && (r >= 2) && (c >= 2);
      drive(v, pix_of(idx), wr, acc);
      cyc++;
      total++; if (acc !== exp_acc) begin bad++; $display("FAIL bub_accept cyc=%0d got=%b want=%b", cyc, acc, exp_acc); end
      total++; if (frame_done !== (exp_acc && idx == 15)) begin bad++; $display("FAIL bub_frame_done cyc=%0d got=%b want=%b", cyc, frame_done, exp_acc && idx == 15); end
      if (em) begin
        exp_wv = 1'b1;
        held = exp_all(r, c);
        nwin++;
      end else if (wr) begin
        exp_wv = 1'b0;
      end
      total++; if (win_valid !== exp_wv) begin bad++; $display("FAIL bub_win_valid cyc=%0d got=%b want=%b", cyc, win_valid, exp_wv); end
      if (exp_wv) begin
        total++; if ({A3, A2, A1} !== held) begin bad++; $display("FAIL bub_window cyc=%0d got=%h want=%h", cyc, {A3, A2, A1}, held); end
      end
      if (exp_acc) idx++;
    end
    total++; if (idx !== 16) begin bad++; $display("FAIL bub_timeout accepted=%0d want=16", idx); end
    total++; if (nwin !== 4) begin bad++; $display("FAIL bub_window_count got=%0d want=4", nwin); end
  endtask

  task automatic test_back_to_back();
    logic         acc, em;
    int           nwin, nfd, r, c;
    logic [161:0] first1;
    do_reset();
    nwin = 0; nfd = 0;
    first1 = '0;
    for (int idx = 0; idx < 32; idx++) begin
      r = (idx % 16) / 4; c = idx % 4;
      em = (r >= 2) && (c >= 2);
      drive(1'b1, pix_of(idx % 16), 1'b1, acc);
      if (win_valid) nwin++;
      if (frame_done) nfd++;
      total++; if (win_valid !== em) begin bad++; $display("FAIL b2b_win_valid idx=%0d got=%b want=%b", idx, win_valid, em); end
      if (em) begin
        total++; if ({A3, A2, A1} !== exp_all(r, c)) begin bad++; $display("FAIL b2b_window idx=%0d got=%h want=%h", idx, {A3, A2, A1}, exp_all(r, c)); end
      end
      if (idx == 10) first1 = {A3, A2, A1};
      if (idx == 26) begin
        total++; if ({A3, A2, A1} !== first1) begin bad++; $display("FAIL b2b_frame2_first got=%h want=%h", {A3, A2, A1}, first1); end
      end
    end
    total++; if (nwin !== 8) begin bad++; $display("FAIL b2b_window_count got=%0d want=8", nwin); end
    total++; if (nfd !== 2) begin bad++; $display("FAIL b2b_frame_done_count got=%0d want=2", nfd); end
  endtask

  task automatic test_mid_reset();
    logic acc, em;
    int   nwin, r, c;
    do_reset();
    for (int idx = 0; idx < 12; idx++) drive(1'b1, pix_of(idx), 1'b1, acc);
    total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL mr_pre_valid got=%b want=1", win_valid); end
    in_valid = 1'b0;
    #2 CLR = 1'b1;
    #1;
    total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL mr_win_valid got=%b want=0", win_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL mr_frame_done got=%b want=0", frame_done); end
    total++; if ({A3, A2, A1} !== 162'd0) begin bad++; $display("FAIL mr_window got=%h want=0", {A3, A2, A1}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mr_in_ready got=%b want=1", in_ready); end
    #2 CLR = 1'b0;
    @(posedge CLK);
    #1;
    nwin = 0;
    for (int idx = 0; idx < 16; idx++) begin
      r = idx / 4; c = idx % 4;
      em = (r >= 2) && (c >= 2);
      drive(1'b1, pix_of(idx), 1'b1, acc);
      if (win_valid) nwin++;
      total++; if (win_valid !== em) begin bad++; $display("FAIL mr_win_valid idx=%0d got=%b want=%b", idx, win_valid, em); end
      total++; if (frame_done !== (idx == 15)) begin bad++; $display("FAIL mr_frame_done idx=%0d got=%b want=%b", idx, frame_done, idx == 15); end
      if (em) begin
        total++; if ({A3, A2, A1} !== exp_all(r, c)) begin bad++; $display("FAIL mr_window idx=%0d got=%h want=%h", idx, {A3, A2, A1}, exp_all(r, c)); end
      end
    end
    total++; if (nwin !== 4) begin bad++; $display("FAIL mr_window_count got=%0d want=4", nwin); end
  endtask

  task automatic test_width_boundary();
    int nwin;
    do_reset();
    nwin = 0;
    for (int idx = 0; idx < 9; idx++) begin
      in_valid3  = 1'b1;
      in_pix3    = 18'h3FFFF;
      win_ready3 = 1'b1;
      #2;
      total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL wb_in_ready idx=%0d got=%b want=1", idx, in_ready3); end
      @(posedge CLK);
      #1;
      if (win_valid3) nwin++;
      total++; if (win_valid3 !== (idx == 8)) begin bad++; $display("FAIL wb_win_valid idx=%0d got=%b want=%b", idx, win_valid3, idx == 8); end
      total++; if (frame_done3 !== (idx == 8)) begin bad++; $display("FAIL wb_frame_done idx=%0d got=%b want=%b", idx, frame_done3, idx == 8); end
      if (idx == 8) begin
        total++; if ({B3, B2, B1} !== {162{1'b1}}) begin bad++; $display("FAIL wb_window got=%h want=all ones", {B3, B2, B1}); end
      end
    end
    in_valid3 = 1'b0;
    @(posedge CLK);
    #1;
    total++; if (win_valid3 !== 1'b0 || frame_done3 !== 1'b0) begin bad++; $display("FAIL wb_after got=%b%b want=00", win_valid3, frame_done3); end
    total++; if (nwin !== 1) begin bad++; $display("FAIL wb_window_count got=%0d want=1", nwin); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    CLR   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    test_width_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2_window_feeder.md
Name: conv2_window_feeder

Overview:
- Streaming front end for the conv2 filter stage.
- Accepts one 3-channel pixel per beat, raster order, 6-bit unsigned activations per channel.
- Keeps two line buffers plus a 3x3x3 window register and emits stride-1, no-padding 3x3 windows packed for the conv2 filter A1/A2/A3 inputs.
- win_valid drives the filter WE; win_ready gives downstream backpressure.

Parameters:
IMG_W, 14, feature-map width in pixels (>=3)
IMG_H, 14, feature-map height in pixels (>=3)
CW, 4, column counter width, must hold IMG_W-1
RW, 4, row counter width, must hold IMG_H-1

Ports:
CLK  input  1  clock, rising edge
CLR  input  1  reset, asynchronous, active-high
in_valid  input  1  pixel beat valid
in_ready  output  1  feeder can accept beat
in_pix  input  18  [5:0] ch1, [11:6] ch2, [17:12] ch3
A1  output  54  ch1 window: element k at [6k-1:6k-6], k=1..9
A2  output  54  ch2 window, same packing
A3  output  54  ch3 window, same packing
win_valid  output  1  A1..A3 hold a valid window (to filter WE)
win_ready  input  1  downstream consumes window this cycle
frame_done  output  1  one-cycle pulse, last window of frame issued

Behaviour:
- Window element order is row-major over window row 0..2 and column 0..2.
  - Element 1 = top-left = pixel (r-2,c-2); element 5 = centre; element 9 = bottom-right = newest pixel (r,c).
- Accept = in_valid && in_ready. in_ready = !win_valid || win_ready (combinational). Nothing is accepted while a window is held unconsumed.
- Per channel, storage is lb0[IMG_W] (previous row) and lb1[IMG_W] (row before that).
- On accept at column col:
  - Window shifts one column left.
  - New right column is {lb1[col], lb0[col], in_pix} for window rows {0,1,2}.
  - lb1[col] <= lb0[col]; lb0[col] <= in_pix.
- Counters col and row advance on accept.
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0, so frames are back-to-back with no gap or start signal.
- Window emit condition: accepted pixel has row>=2 and col>=2. On that edge, win_valid <= 1.
  - Latency: A1..A3 and win_valid are valid in the cycle after the accepting edge.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- win_valid update each edge:
  - Accept with new window: win_valid stays or becomes 1.
  - Else if win_ready: win_valid <= 0.
  - Else: win_valid holds, and A1..A3 hold stable.
- Accepts with row<2 or col<2 shift the window and update line buffers but leave win_valid 0 (after any handshake clears it).
- Column wrap: stale left columns from the previous row are never emitted, because col<2 suppresses emission.
- frame_done pulses together with win_valid rising for pixel (IMG_H-1,IMG_W-1). It stays 1 for exactly one cycle regardless of win_ready.
- Reset (any time, including mid-frame):
  - Async clears col, row, win_valid, frame_done, and A1..A3 to 0.
  - in_ready = 1 after reset.
  - Line-buffer contents are not reset and are don't-care, since rows 0-1 of the next frame overwrite them before use.
- No arithmetic is performed; all values are passed through unchanged at 6 bits.

Test Plan:
- Basic (IMG_W=IMG_H=4): ch1=p=4r+c, ch2=p+16, ch3=p+32, in_valid held 1, win_ready=1.
  - Expect exactly 4 windows.
  - First window, after pixel (2,2): ch1 elements 1..9 = 0,1,2,4,5,6,8,9,10; ch2 = +16; ch3 = +32.
  - Last window ch1 = 5,6,7,9,10,11,13,14,15, with frame_done high in that same cycle.
- Backpressure: hold win_ready=0 for 5 cycles after the first window.
  - in_ready=0, A1..A3 stable, no pixels lost.
  - Release: the following windows match the basic case exactly.
- Bubbles: random in_valid gaps (50%).
  - Identical window sequence to the basic case, and win_valid never asserts on a non-accept cycle except while holding.
- Back-to-back frames: stream 2 frames of 16 pixels.
  - 8 windows total, 2 frame_done pulses.
  - Frame-2 first window equals frame-1 first window when the data pattern repeats.
- Mid-frame reset: assert CLR asynchronously (between edges) after pixel (2,3).
  - win_valid, frame_done, and A1..A3 go 0 immediately.
  - After release, a full fresh frame yields exactly the basic-case results.
- Width boundary (IMG_W=IMG_H=3): a 9-pixel frame produces exactly 1 window with frame_done.
  - Use in_pix all-ones (63 per channel) to check no truncation in the packing.
